// File: rtl/shifter_rr_arbiter.sv
// Round-robin arbiter sharing one registered left barrel shifter between NREQ
// requesters; results leave on a valid/ready channel tagged with the requester ID.
module shifter_rr_arbiter #(
  parameter int WIDTH      = 32,
  parameter int SHIFTWIDTH = 5,
  parameter int NREQ       = 4,
  parameter int CNTW       = 16,
  localparam int IDW       = $clog2(NREQ)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ*WIDTH-1:0]      req_din_i,
  input  logic [NREQ*SHIFTWIDTH-1:0] req_shift_i,
  output logic [NREQ-1:0]            req_ready_o,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           out_data_o,
  output logic [IDW-1:0]             out_id_o,
  input  logic                       out_ready_i,
  output logic [CNTW-1:0]            op_count_o
);

  logic                  out_valid_q, out_valid_d;
  logic [WIDTH-1:0]      out_data_q, out_data_d;
  logic [IDW-1:0]        out_id_q, out_id_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CNTW-1:0]       op_count_q, op_count_d;

  logic                  free;
  logic                  grant_found;
  logic [IDW-1:0]        grant_idx;
  logic                  accept;
  logic                  consume;
  logic [WIDTH-1:0]      sel_din;
  logic [SHIFTWIDTH-1:0] sel_shift;
  int                    scan_idx;

  // Scan starts one past the last winner so the previous owner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = (int'(rr_ptr_q) + k) % NREQ;
      if (!grant_found && req_valid_i[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = IDW'(scan_idx);
      end
    end
  end

  assign free    = !out_valid_q || out_ready_i;
  assign accept  = rst_ni && free && grant_found;
  assign consume = out_valid_q && out_ready_i;

  assign req_ready_o = accept ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;

  assign sel_din   = req_din_i[grant_idx*WIDTH +: WIDTH];
  assign sel_shift = req_shift_i[grant_idx*SHIFTWIDTH +: SHIFTWIDTH];

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    rr_ptr_d    = rr_ptr_q;
    op_count_d  = op_count_q;
    if (consume) begin
      op_count_d  = op_count_q + 1'b1;
      out_valid_d = 1'b0;
    end
    // A new accept overrides the drain so back-to-back results leave no bubble.
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_din << sel_shift;
      out_id_d    = grant_idx;
      rr_ptr_d    = grant_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      rr_ptr_q    <= IDW'(NREQ-1);
      op_count_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      rr_ptr_q    <= rr_ptr_d;
      op_count_q  <= op_count_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_id_o    = out_id_q;
  assign op_count_o  = op_count_q;

endmodule

// File: tb/tb_shifter_rr_arbiter.sv
// Self-checking bench for shifter_rr_arbiter: shift vector table, directed
// multi-cycle sequences and randomized traffic against a cycle-level model.
module tb_shifter_rr_arbiter;
  localparam int WIDTH = 32;
  localparam int SW    = 5;
  localparam int NREQ  = 4;
  localparam int CNTW  = 16;
  localparam int IDW   = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_din;
  logic [NREQ*SW-1:0]    req_shift;
  logic [NREQ-1:0]       req_ready;
  logic                  out_valid;
  logic [WIDTH-1:0]      out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_ready;
  logic [CNTW-1:0]       op_count;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  bit          m_v;
  logic [31:0] m_d;
  int          m_id, m_ptr, m_cnt, last_acc;

  always #5 clk = ~clk;

  shifter_rr_arbiter #(.WIDTH(WIDTH), .SHIFTWIDTH(SW), .NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_din_i(req_din),
    .req_shift_i(req_shift), .req_ready_o(req_ready), .out_valid_o(out_valid),
    .out_data_o(out_data), .out_id_o(out_id), .out_ready_i(out_ready),
    .op_count_o(op_count));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_grant();
    for (int k = 1; k <= NREQ; k++)
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] din, input logic [4:0] sh);
    req_din[i*WIDTH +: WIDTH] = din;
    req_shift[i*SW +: SW]     = sh;
  endtask

  // Called at posedge+1 after inputs are driven; checks at posedge+2, then advances.
  task automatic step(input bit do_chk);
    int g;
    bit free;
    logic [NREQ-1:0] exp_rdy;
    logic [31:0] din;
    #1;
    g = model_grant();
    free = !m_v || out_ready;
    exp_rdy = '0;
    if (free && g >= 0) exp_rdy[g] = 1'b1;
    if (do_chk) begin
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(m_v));
      if (m_v) begin
        chk("out_data", 64'(out_data), 64'(m_d));
        chk("out_id", 64'(out_id), 64'(m_id));
      end
      chk("op_count", 64'(op_count), 64'(m_cnt));
    end
    @(posedge clk);
    last_acc = -1;
    if (m_v && out_ready) begin
      m_cnt = (m_cnt + 1) % (1 << CNTW);
      m_v = 1'b0;
    end
    if (free && g >= 0) begin
      din = req_din[g*WIDTH +: WIDTH];
      m_d = din << req_shift[g*SW +: SW];
      m_id = g; m_ptr = g; m_v = 1'b1; last_acc = g;
    end
    #1;
  endtask

  task automatic model_reset();
    m_v = 0; m_d = 0; m_id = 0; m_ptr = NREQ-1; m_cnt = 0; last_acc = -1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic [31:0] din;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];
  int rr_exp[6];
  int c0;

  initial begin
    vecs[0] = '{32'h00001111, 5'd4,  32'h00011110};
    vecs[1] = '{32'hA5A5A5A5, 5'd0,  32'hA5A5A5A5};
    vecs[2] = '{32'h00000001, 5'd31, 32'h80000000};
    vecs[3] = '{32'hFFFF0000, 5'd3,  32'hFFF80000};
    vecs[4] = '{32'h12345678, 5'd8,  32'h34567800};
    vecs[5] = '{32'h80000001, 5'd1,  32'h00000002};
    vecs[6] = '{32'hFFFFFFFF, 5'd16, 32'hFFFF0000};
    vecs[7] = '{32'hDEADBEEF, 5'd31, 32'h80000000};
    rr_exp = '{0, 1, 2, 3, 0, 1};
    req_din = '0; req_shift = '0;

    do_reset();
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", 64'(out_data), 64'd0);
    chk("rst out_id", 64'(out_id), 64'd0);
    chk("rst op_count", 64'(op_count), 64'd0);
    chk("rst req_ready", 64'(req_ready), 64'd0);

    // shift table through requester 0, one accept per cycle
    out_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      set_req(0, vecs[v].din, vecs[v].sh);
      req_valid = 4'b0001;
      step(1);
      chk("vec out_data", 64'(out_data), 64'(vecs[v].din == 32'h00001111 ? 32'h00011110 : vecs[v].exp));
      chk("vec out_id", 64'(out_id), 64'd0);
    end
    req_valid = '0;
    step(1);

    // round robin with all requesters valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h100 + i, 5'(i));
    req_valid = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      step(1);
      chk("rr out_id", 64'(out_id), 64'(rr_exp[n]));
      chk("rr out_valid", 64'(out_valid), 64'd1);
    end
    req_valid = '0;
    step(1);

    // backpressure on requester 2
    do_reset();
    set_req(2, 32'hFFFF0000, 5'd3);
    req_valid = 4'b0100;
    out_ready = 1'b0;
    step(1);
    c0 = int'(op_count);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step(1);
      chk("bp req_ready", 64'(req_ready), 64'd0);
      chk("bp out_data", 64'(out_data), 64'h00000000FFF80000);
      chk("bp out_id", 64'(out_id), 64'd2);
      chk("bp op_count", 64'(op_count), 64'(c0));
    end
    req_valid = '0;
    out_ready = 1'b1;
    step(1);
    chk("bp release op_count", 64'(op_count), 64'(c0 + 1));
    chk("bp release out_valid", 64'(out_valid), 64'd0);

    // back-to-back drain+accept: req1 then req3
    set_req(1, 32'h0000000F, 5'd4);
    set_req(3, 32'h0000000F, 5'd8);
    req_valid = 4'b0010;
    step(1);
    chk("b2b out_valid 1", 64'(out_valid), 64'd1);
    chk("b2b out_id 1", 64'(out_id), 64'd1);
    chk("b2b out_data 1", 64'(out_data), 64'h000000F0);
    req_valid = 4'b1000;
    step(1);
    chk("b2b out_valid 2", 64'(out_valid), 64'd1);
    chk("b2b out_id 2", 64'(out_id), 64'd3);
    chk("b2b out_data 2", 64'(out_data), 64'h00000F00);
    req_valid = '0;
    step(1);

    // op_count wrap
    do_reset();
    set_req(0, 32'h1, 5'd1);
    req_valid = 4'b0001;
    out_ready = 1'b1;
    for (int n = 0; n < 65536; n++) step(0);
    #1;
    chk("wrap op_count ffff", 64'(op_count), 64'hFFFF);
    step(1);
    chk("wrap op_count 0", 64'(op_count), 64'd0);

    // async reset while a result is pending
    req_valid = 4'b1111;
    chk("pre-rst out_valid", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", 64'(out_valid), 64'd0);
    chk("async op_count", 64'(op_count), 64'd0);
    chk("async req_ready", 64'(req_ready), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    chk("in-rst req_ready", 64'(req_ready), 64'd0);
    rst_n = 1'b1;
    step(1);
    chk("post-rst first id", 64'(out_id), 64'd0);

    // randomized traffic obeying the hold-while-waiting rule
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && last_acc != i) begin
          if ($urandom_range(7) == 0) req_valid[i] = 1'b0;
        end else begin
          req_valid[i] = 1'($urandom_range(1));
          set_req(i, $urandom, 5'($urandom_range(31)));
        end
      end
      out_ready = ($urandom_range(3) != 0);
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
